// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: command opcodes and their decode.
package lifo_stack_pkg;

  localparam logic [2:0] OP_IDLE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_TOP  = 3'd3;
  localparam logic [2:0] OP_REPL = 3'd4;

  // push/pop outrank top; push together with pop is a replace of the top entry
  function automatic logic [2:0] op_decode(input logic push, input logic pop, input logic top);
    logic [2:0] op;
    if (push && pop)  op = OP_REPL;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
    else if (top)     op = OP_TOP;
    else              op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module lifo_stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with status, sticky error flags and push+pop replace.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]       op;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             ovf_evt;
  logic             unf_evt;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Command decode: write strobe/address and error events from the pre-edge count
  always_comb begin
    op      = op_decode(push, pop, top);
    raddr   = AW'(count - CW'(1));
    we      = 1'b0;
    waddr   = AW'(count);
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      OP_PUSH: begin
        we      = !full;
        ovf_evt = full;
      end
      OP_POP, OP_TOP: unf_evt = empty;
      OP_REPL: begin
        // on an empty stack this degenerates to a plain push into entry 0
        we      = 1'b1;
        unf_evt = empty;
        if (!empty) waddr = raddr;
      end
      default: ;
    endcase
  end

  lifo_stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (d_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Occupancy and registered read data with its one-cycle valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      d_out   <= '0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      case (op)
        OP_PUSH: if (!full) count <= count + CW'(1);
        OP_POP: if (!empty) begin
          count   <= count - CW'(1);
          d_out   <= rdata;
          d_valid <= 1'b1;
        end
        OP_TOP: if (!empty) begin
          d_out   <= rdata;
          d_valid <= 1'b1;
        end
        OP_REPL: begin
          if (empty) begin
            count <= CW'(1);
          end else begin
            d_out   <= rdata;
            d_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (ovf && !clr_err) || ovf_evt;
      unf <= (unf && !clr_err) || unf_evt;
    end
  end

endmodule
